// File: rtl/exc_req_ctrl.sv
// exc_req_ctrl: initiator side of the CP0 exception interface.
// Collects SYSCALL/BREAK/TEQ requests from the decoder and external IRQs,
// masks them with CP0 status, prioritises them and issues single-cycle
// exception/eret pulses with cause code and EPC. Stalls the PC while the
// entry and return sequences are in progress.
module exc_req_ctrl #(
    parameter int unsigned IRQ_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sys_req,
    input  logic             brk_req,
    input  logic             teq_req,
    input  logic             eret_req,
    input  logic [IRQ_W-1:0] irq,
    input  logic [31:0]      status,
    input  logic [31:0]      pc_cur,
    output logic             exception,
    output logic [4:0]       cause,
    output logic [31:0]      epc,
    output logic             eret,
    output logic             stall,
    output logic [IRQ_W-1:0] irq_ack,
    output logic             in_handler,
    output logic             nest_err
);

    localparam logic [4:0] CAUSE_INT = 5'b00000;
    localparam logic [4:0] CAUSE_SYS = 5'b01000;
    localparam logic [4:0] CAUSE_BRK = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ = 5'b01101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cause_q, cause_d;
    logic [31:0]      epc_q, epc_d;
    logic [IRQ_W-1:0] ack_q, ack_d;
    logic [IRQ_W-1:0] pending_q, pending_d;
    logic             nest_q, nest_d;

    logic [IRQ_W-1:0] sync_q [SYNC_STAGES];
    logic [IRQ_W-1:0] irq_prev_q;
    logic [IRQ_W-1:0] irq_rise;
    logic [IRQ_W-1:0] irq_pick;
    logic [IRQ_W-1:0] take_mask;

    logic             gie;
    logic             teq_ok;
    logic             brk_ok;
    logic             sys_ok;
    logic             irq_ok;
    logic             any_sync_req;

    // Only the enable bits of status are meaningful here.
    logic             unused_status;
    assign unused_status = ^status[31:5];

    // IRQ synchronizer chain plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            irq_prev_q <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            irq_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~irq_prev_q;

    // Lowest-index pending IRQ, isolated as a one-hot mask.
    assign irq_pick = pending_q & (~pending_q + IRQ_W'(1));

    assign gie          = status[0];
    assign teq_ok       = teq_req & gie & status[3];
    assign brk_ok       = brk_req & gie & status[2];
    assign sys_ok       = sys_req & gie & status[1];
    assign irq_ok       = gie & status[4] & (|pending_q);
    assign any_sync_req = sys_req | brk_req | teq_req;

    // Next-state, capture and pending-update logic.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        ack_d     = ack_q;
        nest_d    = nest_q;
        take_mask = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Masked sync requests fall through to the next candidate
                // and are dropped; masked IRQs simply stay pending.
                if (teq_ok) begin
                    cause_d = CAUSE_TEQ;
                    epc_d   = pc_cur;
                    ack_d   = '0;
                    state_d = ST_ENTRY;
                end else if (brk_ok) begin
                    cause_d = CAUSE_BRK;
                    epc_d   = pc_cur;
                    ack_d   = '0;
                    state_d = ST_ENTRY;
                end else if (sys_ok) begin
                    cause_d = CAUSE_SYS;
                    epc_d   = pc_cur;
                    ack_d   = '0;
                    state_d = ST_ENTRY;
                end else if (irq_ok) begin
                    cause_d   = CAUSE_INT;
                    epc_d     = pc_cur;
                    ack_d     = irq_pick;
                    take_mask = irq_pick;
                    state_d   = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (any_sync_req) begin
                    nest_d = 1'b1;
                end
                if (eret_req) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh edge on the bit being taken re-arms it rather than being lost.
        pending_d = (pending_q & ~take_mask) | irq_rise;
    end

    // State, captured cause/epc/ack, pending IRQs and sticky nest error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= '0;
            epc_q     <= '0;
            ack_q     <= '0;
            pending_q <= '0;
            nest_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            ack_q     <= ack_d;
            pending_q <= pending_d;
            nest_q    <= nest_d;
        end
    end

    // Outputs decode directly from registered state so reset clears them at once.
    always_comb begin
        exception  = (state_q == ST_ENTRY);
        eret       = (state_q == ST_RETURN);
        stall      = (state_q == ST_ENTRY) || (state_q == ST_RETURN);
        in_handler = (state_q == ST_HANDLER);
        irq_ack    = (state_q == ST_ENTRY) ? ack_q : '0;
        cause      = cause_q;
        epc        = epc_q;
        nest_err   = nest_q;
    end

endmodule

// File: tb/tb_exc_req_ctrl.sv
// Testbench for exc_req_ctrl: directed scenarios followed by randomized
// traffic, all cycles compared against a behavioural reference model.
module tb_exc_req_ctrl;

    localparam int IRQ_W = 4;
    localparam int SYNC  = 2;

    localparam int P_IDLE    = 0;
    localparam int P_ENTRY   = 1;
    localparam int P_HANDLER = 2;
    localparam int P_RETURN  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             sys_req, brk_req, teq_req, eret_req;
    logic [IRQ_W-1:0] irq;
    logic [31:0]      status;
    logic [31:0]      pc_cur;
    logic             exception;
    logic [4:0]       cause;
    logic [31:0]      epc;
    logic             eret;
    logic             stall;
    logic [IRQ_W-1:0] irq_ack;
    logic             in_handler;
    logic             nest_err;

    always #5 clk = ~clk;

    exc_req_ctrl #(
        .IRQ_W      (IRQ_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sys_req   (sys_req),
        .brk_req   (brk_req),
        .teq_req   (teq_req),
        .eret_req  (eret_req),
        .irq       (irq),
        .status    (status),
        .pc_cur    (pc_cur),
        .exception (exception),
        .cause     (cause),
        .epc       (epc),
        .eret      (eret),
        .stall     (stall),
        .irq_ack   (irq_ack),
        .in_handler(in_handler),
        .nest_err  (nest_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int               m_phase;
    logic [4:0]       m_cause;
    logic [31:0]      m_epc;
    logic [IRQ_W-1:0] m_ack;
    logic [IRQ_W-1:0] m_pend;
    logic             m_nest;
    logic [IRQ_W-1:0] m_hist [0:SYNC];   // irq samples, [0] = most recent clock

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_cause = '0;
        m_epc   = '0;
        m_ack   = '0;
        m_pend  = '0;
        m_nest  = 1'b0;
        for (int i = 0; i <= SYNC; i++) m_hist[i] = '0;
    endtask

    // One clock of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        logic [IRQ_W-1:0] rise;
        logic [IRQ_W-1:0] take;
        logic             gie;
        logic             accepted;
        bit               found;
        // An irq level reaches the edge detector SYNC clocks after being sampled.
        rise = m_hist[SYNC-1] & ~m_hist[SYNC];
        for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = irq;

        take     = '0;
        accepted = 1'b0;
        gie      = status[0];
        case (m_phase)
            P_IDLE: begin
                if (teq_req && gie && status[3]) begin
                    m_cause = 5'd13; accepted = 1'b1;
                end else if (brk_req && gie && status[2]) begin
                    m_cause = 5'd9;  accepted = 1'b1;
                end else if (sys_req && gie && status[1]) begin
                    m_cause = 5'd8;  accepted = 1'b1;
                end else if (gie && status[4] && m_pend != '0) begin
                    found = 0;
                    for (int i = 0; i < IRQ_W; i++) begin
                        if (m_pend[i] && !found) begin
                            take[i] = 1'b1;
                            found   = 1;
                        end
                    end
                    m_cause  = 5'd0;
                    accepted = 1'b1;
                end
                if (accepted) begin
                    m_epc   = pc_cur;
                    m_ack   = take;
                    m_phase = P_ENTRY;
                end
            end
            P_ENTRY: m_phase = P_HANDLER;
            P_HANDLER: begin
                if (sys_req || brk_req || teq_req) m_nest = 1'b1;
                if (eret_req) m_phase = P_RETURN;
            end
            default: m_phase = P_IDLE;
        endcase
        m_pend = (m_pend & ~take) | rise;
    endtask

    task automatic check_outputs();
        check_eq("exception",  exception,  32'(m_phase == P_ENTRY));
        check_eq("eret",       eret,       32'(m_phase == P_RETURN));
        check_eq("stall",      stall,      32'(m_phase == P_ENTRY || m_phase == P_RETURN));
        check_eq("in_handler", in_handler, 32'(m_phase == P_HANDLER));
        check_eq("irq_ack",    irq_ack,    (m_phase == P_ENTRY) ? 32'(m_ack) : 32'd0);
        check_eq("cause",      cause,      32'(m_cause));
        check_eq("epc",        epc,        m_epc);
        check_eq("nest_err",   nest_err,   32'(m_nest));
    endtask

    // Inputs are driven at the falling edge; model advances on the rising edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_req();
        sys_req  = 1'b0;
        brk_req  = 1'b0;
        teq_req  = 1'b0;
        eret_req = 1'b0;
    endtask

    task automatic wait_exc(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (exception) break;
        end
        check_eq(tag, exception, 1);
    endtask

    // From ENTRY: one cycle to HANDLER, eret, RETURN, back to IDLE.
    task automatic leave_handler();
        step();
        eret_req = 1'b1;
        step();
        eret_req = 1'b0;
        step();
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        clear_req();
        irq    = '0;
        status = 32'h1F;
        pc_cur = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Syscall accepted, exception one cycle later with its PC
        status = 32'h1F;
        pc_cur = 32'h0040_0100;
        sys_req = 1'b1;
        step();
        clear_req();
        check_eq("t1_exception", exception, 1);
        check_eq("t1_cause", cause, 32'h08);
        check_eq("t1_epc", epc, 32'h0040_0100);
        check_eq("t1_stall", stall, 1);
        leave_handler();

        // Masked syscall is dropped
        status = 32'h1D;
        sys_req = 1'b1;
        step();
        clear_req();
        check_eq("t3_exception", exception, 0);
        step();
        check_eq("t3_in_handler", in_handler, 0);
        check_eq("t3_nest_err", nest_err, 0);

        // TEQ beats BREAK and an IRQ edge; IRQ is taken after eret
        status  = 32'h1F;
        pc_cur  = 32'h0040_0200;
        teq_req = 1'b1;
        brk_req = 1'b1;
        irq     = 4'b0100;
        step();
        clear_req();
        check_eq("t2_cause", cause, 32'h0D);
        check_eq("t2_ack_sync", irq_ack, 0);
        repeat (4) step();
        eret_req = 1'b1;
        step();
        eret_req = 1'b0;
        step();
        wait_exc("t2_irq_taken", 10);
        check_eq("t2_irq_cause", cause, 0);
        check_eq("t2_irq_ack", irq_ack, 32'b0100);
        leave_handler();
        irq = '0;
        repeat (3) step();

        // Two IRQs together: lowest index first
        status = 32'h11;
        irq    = 4'b1010;
        wait_exc("t4_first", 10);
        check_eq("t4_ack_first", irq_ack, 32'b0010);
        leave_handler();
        wait_exc("t4_second", 10);
        check_eq("t4_ack_second", irq_ack, 32'b1000);
        leave_handler();
        irq = '0;
        repeat (3) step();

        // Request inside handler sets nest_err; eret pulse lasts one cycle
        status = 32'h1F;
        sys_req = 1'b1;
        step();
        clear_req();
        step();
        brk_req = 1'b1;
        step();
        clear_req();
        check_eq("t5_nest_err", nest_err, 1);
        check_eq("t5_no_pulse", exception, 0);
        eret_req = 1'b1;
        step();
        eret_req = 1'b0;
        check_eq("t5_eret", eret, 1);
        step();
        check_eq("t5_eret_done", eret, 0);
        check_eq("t5_idle", in_handler, 0);

        // Reset during ENTRY clears outputs and a pending (masked) IRQ
        status = 32'h01;
        irq    = 4'b0001;
        repeat (5) step();
        irq     = '0;
        status  = 32'h03;
        sys_req = 1'b1;
        step();
        clear_req();
        check_eq("t6_in_entry", exception, 1);
        async_reset();
        check_eq("t6_exc_cleared", exception, 0);
        check_eq("t6_nest_cleared", nest_err, 0);
        status = 32'h1F;
        repeat (8) step();
        check_eq("t6_pending_cleared", in_handler, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sys_req  = ($urandom_range(0, 5) == 0);
            brk_req  = ($urandom_range(0, 5) == 0);
            teq_req  = ($urandom_range(0, 5) == 0);
            eret_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                int idx;
                idx = $urandom_range(0, IRQ_W - 1);
                irq[idx] = ~irq[idx];
            end
            if ($urandom_range(0, 9) < 7) status = 32'h1F;
            else                          status = $urandom;
            pc_cur = $urandom;
            step();
            if (c % 1000 == 999) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
